// File: rtl/a_lane_loader.sv
// Feeder for the three-lane consumer: gathers three beats into shadows, commits
// them atomically, then holds off input for `delay` cycles. Optional: LANE_LOADER_CNT_EN.
module a_lane_loader #(
    parameter int g_w1  = 8,
    parameter int g_w2  = 6,
    parameter int g_w3  = 4,
    parameter int in_w  = 16,
    parameter int delay = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [in_w-1:0]     in_data,
    input  logic                in_valid,
    input  logic                in_first,
    output logic                in_ready,
    output logic [g_w1-1:0]     d1,
    output logic [g_w2+1:0]     d2,
    output logic [g_w3*2-1:0]   d3,
    output logic                d_upd,
    output logic                sync_err
`ifdef LANE_LOADER_CNT_EN
    ,
    output logic [15:0]         set_cnt
`endif
);
    localparam int W1 = g_w1;
    localparam int W2 = g_w2 + 2;
    localparam int W3 = g_w3 * 2;
    localparam logic [7:0] DLY_M1 = (delay > 0) ? 8'(delay - 1) : 8'd0;

    typedef enum logic [1:0] {L1, L2, L3, HOLD} state_t;

    state_t          state_q, state_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [W1-1:0]   sh1_q, sh1_d;
    logic [W2-1:0]   sh2_q, sh2_d;
    logic [W1-1:0]   d1_q, d1_d;
    logic [W2-1:0]   d2_q, d2_d;
    logic [W3-1:0]   d3_q, d3_d;
    logic            upd_q, upd_d;
    logic            err_q, err_d;
    logic            accept;

    assign in_ready = (state_q != HOLD);
    assign accept   = in_valid & in_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh1_d   = sh1_q;
        sh2_d   = sh2_q;
        d1_d    = d1_q;
        d2_d    = d2_q;
        d3_d    = d3_q;
        upd_d   = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            L1: begin
                if (accept) begin
                    sh1_d   = in_data[W1-1:0];
                    state_d = L2;
                end
            end
            L2, L3: begin
                if (accept) begin
                    if (in_first) begin
                        // Resync: this beat starts a fresh set, partial one is dropped.
                        sh1_d   = in_data[W1-1:0];
                        err_d   = 1'b1;
                        state_d = L2;
                    end else if (state_q == L2) begin
                        sh2_d   = in_data[W2-1:0];
                        state_d = L3;
                    end else begin
                        d1_d  = sh1_q;
                        d2_d  = sh2_q;
                        d3_d  = in_data[W3-1:0];
                        upd_d = 1'b1;
                        if (delay == 0) begin
                            state_d = L1;
                        end else begin
                            cnt_d   = DLY_M1;
                            state_d = HOLD;
                        end
                    end
                end
            end
            HOLD: begin
                if (cnt_q == 8'd0) state_d = L1;
                else               cnt_d   = cnt_q - 8'd1;
            end
            default: state_d = L1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= L1;
            cnt_q   <= '0;
            sh1_q   <= '0;
            sh2_q   <= '0;
            d1_q    <= '0;
            d2_q    <= '0;
            d3_q    <= '0;
            upd_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh1_q   <= sh1_d;
            sh2_q   <= sh2_d;
            d1_q    <= d1_d;
            d2_q    <= d2_d;
            d3_q    <= d3_d;
            upd_q   <= upd_d;
            err_q   <= err_d;
        end
    end

    assign d1       = d1_q;
    assign d2       = d2_q;
    assign d3       = d3_q;
    assign d_upd    = upd_q;
    assign sync_err = err_q;

`ifdef LANE_LOADER_CNT_EN
    logic [15:0] set_cnt_q;

    // Advances on the same edge that raises d_upd; wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     set_cnt_q <= '0;
        else if (upd_d) set_cnt_q <= set_cnt_q + 16'd1;
    end

    assign set_cnt = set_cnt_q;
`endif

endmodule

// File: tb/tb_a_lane_loader.sv
// Directed bench: instance A uses default parameters, instance B uses g_w3=3, delay=0.
module tb_a_lane_loader;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic [15:0] a_data = '0;
    logic        a_valid = 1'b0, a_first = 1'b0;
    logic        a_ready, a_upd, a_err;
    logic [7:0]  a_d1, a_d2, a_d3;

    logic [15:0] b_data = '0;
    logic        b_valid = 1'b0, b_first = 1'b0;
    logic        b_ready, b_upd, b_err;
    logic [7:0]  b_d1, b_d2;
    logic [5:0]  b_d3;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef LANE_LOADER_CNT_EN
    logic [15:0] a_cnt, b_cnt;
`endif

    a_lane_loader u_a (
        .clk(clk), .rst_n(rst_n), .in_data(a_data), .in_valid(a_valid),
        .in_first(a_first), .in_ready(a_ready), .d1(a_d1), .d2(a_d2), .d3(a_d3),
        .d_upd(a_upd), .sync_err(a_err)
`ifdef LANE_LOADER_CNT_EN
        , .set_cnt(a_cnt)
`endif
    );

    a_lane_loader #(.g_w1(8), .g_w2(6), .g_w3(3), .in_w(16), .delay(0)) u_b (
        .clk(clk), .rst_n(rst_n), .in_data(b_data), .in_valid(b_valid),
        .in_first(b_first), .in_ready(b_ready), .d1(b_d1), .d2(b_d2), .d3(b_d3),
        .d_upd(b_upd), .sync_err(b_err)
`ifdef LANE_LOADER_CNT_EN
        , .set_cnt(b_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Present one beat on A, wait (bounded) for in_ready, return #1 after the accepting edge.
    task automatic a_beat(input logic [15:0] d, input logic f);
        int n = 0;
        @(negedge clk);
        a_data = d; a_first = f; a_valid = 1'b1;
        while (!a_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        n_tests++;
        if (n >= 50) begin
            n_fail++;
            $display("FAIL a_beat_timeout: in_ready stayed 0 for %0d cycles, need 1", n);
        end
        @(posedge clk); #1;
        a_valid = 1'b0; a_first = 1'b0;
    endtask

    task automatic test_reset;
        n_tests++;
        if ({a_ready, a_upd, a_err, a_d1, a_d2, a_d3} !== {1'b1, 1'b0, 1'b0, 24'h0}) begin
            n_fail++;
            $display("FAIL reset_a: rdy/upd/err/d=%b%b%b %h, need 100 000000",
                     a_ready, a_upd, a_err, {a_d1, a_d2, a_d3});
        end
        n_tests++;
        if ({b_ready, b_upd, b_err, b_d1, b_d2, b_d3} !== {1'b1, 1'b0, 1'b0, 22'h0}) begin
            n_fail++;
            $display("FAIL reset_b: rdy/upd/err=%b%b%b d=%h %h %h, need 100 0 0 0",
                     b_ready, b_upd, b_err, b_d1, b_d2, b_d3);
        end
    endtask

    task automatic test_basic_set;
        int zeros = 0;
        a_beat(16'h00AA, 1'b1);
        a_beat(16'h00BB, 1'b0);
        n_tests++;
        if (a_upd !== 1'b0 || a_d1 !== 8'h00) begin
            n_fail++;
            $display("FAIL basic_early: upd=%b d1=%h, need 0 00", a_upd, a_d1);
        end
        a_beat(16'h00CC, 1'b0);
        n_tests++;
        if ({a_d1, a_d2, a_d3, a_upd, a_err} !== {24'hAABBCC, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL basic_commit: d=%h upd=%b err=%b, need aabbcc 1 0",
                     {a_d1, a_d2, a_d3}, a_upd, a_err);
        end
        while (!a_ready && zeros < 20) begin
            zeros++;
            @(posedge clk); #1;
        end
        n_tests++;
        if (zeros != 5) begin
            n_fail++;
            $display("FAIL hold_len: in_ready low %0d cycles, need 5", zeros);
        end
        n_tests++;
        if (a_upd !== 1'b0 || a_d1 !== 8'hAA) begin
            n_fail++;
            $display("FAIL upd_pulse: upd=%b d1=%h, need 0 aa", a_upd, a_d1);
        end
    endtask

    task automatic test_truncation;
        a_beat(16'h0000, 1'b1);
        a_beat(16'h1234, 1'b0);
        a_beat(16'hABCD, 1'b0);
        n_tests++;
        if ({a_d1, a_d2, a_d3} !== 24'h0034CD) begin
            n_fail++;
            $display("FAIL trunc_a: d=%h, need 0034cd", {a_d1, a_d2, a_d3});
        end
    endtask

    task automatic test_resync;
        a_beat(16'h0011, 1'b1);
        a_beat(16'h0022, 1'b1);
        n_tests++;
        if (a_err !== 1'b1 || a_upd !== 1'b0 || a_d1 !== 8'h00) begin
            n_fail++;
            $display("FAIL resync_pulse: err=%b upd=%b d1=%h, need 1 0 00", a_err, a_upd, a_d1);
        end
        a_beat(16'h0033, 1'b0);
        n_tests++;
        if (a_err !== 1'b0 || a_upd !== 1'b0) begin
            n_fail++;
            $display("FAIL resync_once: err=%b upd=%b, need 0 0", a_err, a_upd);
        end
        a_beat(16'h0044, 1'b0);
        n_tests++;
        if ({a_d1, a_d2, a_d3, a_upd} !== {24'h223344, 1'b1}) begin
            n_fail++;
            $display("FAIL resync_commit: d=%h upd=%b, need 223344 1", {a_d1, a_d2, a_d3}, a_upd);
        end
    endtask

    // in_valid stays high with changing data through HOLD; only the value present
    // once in_ready rises (6th negedge after commit) may be taken.
    task automatic test_hold_stall;
        a_beat(16'h0001, 1'b1);
        a_beat(16'h0002, 1'b0);
        a_beat(16'h0003, 1'b0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            a_data = 16'h00E0 + 16'(k); a_first = 1'b1; a_valid = 1'b1;
            n_tests++;
            if (a_ready !== (k == 5)) begin
                n_fail++;
                $display("FAIL hold_ready_%0d: in_ready=%b, need %b", k, a_ready, k == 5);
            end
        end
        @(posedge clk); #1;
        a_valid = 1'b0; a_first = 1'b0;
        a_beat(16'h0066, 1'b0);
        a_beat(16'h0077, 1'b0);
        n_tests++;
        if ({a_d1, a_d2, a_d3, a_upd} !== {24'hE56677, 1'b1}) begin
            n_fail++;
            $display("FAIL hold_stall: d=%h upd=%b, need e56677 1", {a_d1, a_d2, a_d3}, a_upd);
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] vals [6];
        vals = '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0006};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            b_data = vals[i]; b_first = (i % 3 == 0); b_valid = 1'b1;
            n_tests++;
            if (b_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_ready_%0d: in_ready=%b, need 1", i, b_ready);
            end
            @(posedge clk); #1;
            n_tests++;
            if (b_upd !== (i % 3 == 2)) begin
                n_fail++;
                $display("FAIL b2b_upd_%0d: d_upd=%b, need %b", i, b_upd, i % 3 == 2);
            end
            if (i == 2) begin
                n_tests++;
                if ({b_d1, b_d2, b_d3} !== {8'h01, 8'h02, 6'h03}) begin
                    n_fail++;
                    $display("FAIL b2b_set0: d=%h %h %h, need 01 02 03", b_d1, b_d2, b_d3);
                end
            end
        end
        b_valid = 1'b0; b_first = 1'b0;
        n_tests++;
        if ({b_d1, b_d2, b_d3} !== {8'h04, 8'h05, 6'h06}) begin
            n_fail++;
            $display("FAIL b2b_set1: d=%h %h %h, need 04 05 06", b_d1, b_d2, b_d3);
        end
        // Lane-3 width 6 on this instance: 0xFFFF must truncate to 0x3F.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            b_data = (i == 2) ? 16'hFFFF : 16'h1234; b_first = (i == 0); b_valid = 1'b1;
            @(posedge clk); #1;
        end
        b_valid = 1'b0; b_first = 1'b0;
        n_tests++;
        if ({b_d1, b_d2, b_d3, b_upd} !== {8'h34, 8'h34, 6'h3F, 1'b1}) begin
            n_fail++;
            $display("FAIL trunc_b: d=%h %h %h upd=%b, need 34 34 3f 1", b_d1, b_d2, b_d3, b_upd);
        end
    endtask

    task automatic test_reset_mid_set;
        a_beat(16'h00F1, 1'b1);
        a_beat(16'h00F2, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({a_ready, a_upd, a_err, a_d1, a_d2, a_d3} !== {1'b1, 1'b0, 1'b0, 24'h0}) begin
            n_fail++;
            $display("FAIL mid_reset: rdy/upd/err=%b%b%b d=%h, need 100 000000",
                     a_ready, a_upd, a_err, {a_d1, a_d2, a_d3});
        end
        @(negedge clk);
        rst_n = 1'b1;
        a_beat(16'h000A, 1'b0);
        a_beat(16'h000B, 1'b0);
        n_tests++;
        if (a_upd !== 1'b0 || a_d1 !== 8'h00) begin
            n_fail++;
            $display("FAIL post_reset_early: upd=%b d1=%h, need 0 00", a_upd, a_d1);
        end
        a_beat(16'h000C, 1'b0);
        n_tests++;
        if ({a_d1, a_d2, a_d3, a_upd} !== {24'h0A0B0C, 1'b1}) begin
            n_fail++;
            $display("FAIL post_reset_set: d=%h upd=%b, need 0a0b0c 1", {a_d1, a_d2, a_d3}, a_upd);
        end
`ifdef LANE_LOADER_CNT_EN
        n_tests++;
        if (a_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL set_cnt: %0d, need 1", a_cnt);
        end
`endif
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_basic_set();
        test_truncation();
        test_resync();
        test_hold_stall();
        test_back_to_back();
        test_reset_mid_set();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
